fetch_insn_queue: RTL and testbench
===================================

# fetch_insn_queue

Parametrised instruction-granular fetch queue that sits between the instruction cache/BPU stage and the 2-wide decoder in `frontend`. It accepts fetch bundles of `C_FETCH_WIDTH` instruction lanes with an arbitrary valid mask and compacts them into a circular buffer. It re-aligns them across bundle boundaries and presents up to two sequential instructions per cycle to decode. It supports any fetch width, any power-of-two depth, per-lane exceptions and a single predicted-taken lane per bundle.

## Interface
- `C_FETCH_WIDTH`, 4: instruction lanes per fetch bundle; legal values 2, 4, 8.
- `C_DEPTH`, 16: queue capacity in instructions; power of two, at least 2*`C_FETCH_WIDTH`.
- `core_clock_i` in 1: single clock; all state updates on rising edge.
- `core_reset_ni` in 1: reset, asynchronous and active-low.
- `core_flush_i` in 1: discard all queued instructions and the current push.
- `push_valid_i` in 1: fetch bundle offered.
- `push_ready_o` out 1: the queue has at least `C_FETCH_WIDTH` free slots.
- `push_pc_i` in 30: word PC of lane 0.
- `push_mask_i` in `C_FETCH_WIDTH`: lane valid mask; lane i has PC `push_pc_i`+i.
- `push_insn_i` in 32*`C_FETCH_WIDTH`: lane i occupies bits [32i+31:32i].
- `push_excp_vld_i` in 1: fetch exception (bus denied/corrupt); applies to the lowest valid lane only.
- `push_excp_code_i` in 4: exception code.
- `push_pred_vld_i` in 1: BPU predicted a taken branch in this bundle.
- `push_pred_lane_i` in clog2(`C_FETCH_WIDTH`): lane holding the predicted branch.
- `push_pred_target_i` in 30: predicted target.
- `ins0_valid_o`, `ins1_valid_o` out 1: decode slot valid.
- `ins0_insn_o`, `ins1_insn_o` out 32: instruction words.
- `insbundle_pc_o` out 30: PC of ins0.
- `ins0_excp_vld_o`, `ins0_excp_code_o` out 1/4: ins0 exception.
- `ins1_excp_vld_o`, `ins1_excp_code_o` out 1/4: ins1 exception.
- `pred_vld_o` out 1: one of the issued instructions is predicted taken.
- `pred_idx_o` out 1: slot of the predicted instruction.
- `pred_target_o` out 30: its target.
- `rn_busy_i` in 1: decode/rename stall.
- `occupancy_o` out clog2(`C_DEPTH`)+1: instructions held.

## Operation
- Entry fields: insn[31:0], pc[29:0], excp_vld, excp_code[3:0], pred_tkn, pred_target[29:0].
- Push fires when `push_valid_i & push_ready_o & ~core_flush_i`.
  - Valid lanes are compacted in ascending lane order and written at the tail.
  - Tail advances by popcount(`push_mask_i`) mod `C_DEPTH`.
  - Lanes above `push_pred_lane_i` are dropped when `push_pred_vld_i` is set, even if their mask bits are set.
  - An all-zero effective mask fires but writes nothing.
- The exception is attached to the lowest valid lane. The prediction is attached to lane `push_pred_lane_i`; if that lane's mask bit is clear, the prediction is discarded.
- Issue: `ins0_valid_o` = occupancy≥1. `ins1_valid_o` requires all of:
  - occupancy≥2;
  - head+1 pc == head pc+1;
  - head pred_tkn=0;
  - head excp_vld=0.
- Pop occurs when `~rn_busy_i`. Head advances by `ins0_valid_o`+`ins1_valid_o`.
- Outputs are combinational reads of the head and head+1 entries; their data is don't-care when the corresponding valid is low, but must be stable.
- `pred_*` reflects the head entry if its pred_tkn=1 (idx 0), otherwise ins1 if issued and pred_tkn=1 (idx 1), otherwise 0.
- Flush: head, tail and count are cleared on the next edge. A same-cycle push and pop are ignored. Entry RAM is not cleared.

## Timing
- Reset values:
  - `push_ready_o`=1;
  - all `*_valid_o`, `*_excp_vld_o` and `pred_vld_o` = 0;
  - `occupancy_o`=0;
  - pointers=0.
- Latency: a pushed instruction is visible on `ins0` in the cycle after the push edge. There is no bypass when empty.
- `push_ready_o` = (C_DEPTH − count ≥ C_FETCH_WIDTH), computed from the registered count. A same-cycle pop does not raise it.
- Simultaneous push and pop: count_next = count + pushed − popped. This never overflows or underflows.
- Pointers are clog2(`C_DEPTH`) bits and wrap naturally. Compaction writes may straddle the wrap.
- Full (count=`C_DEPTH`): ready=0. Issue continues.
- Empty: both valids=0, and `rn_busy_i` is ignored.
- Reset asserted mid-operation clears state immediately (asynchronously). The first push is accepted on the first edge after release.

## Structure
- Package `fetch_pkg`: the `fetch_entry_t` struct, a localparam for the PC width (30), and the exception-code constants shared with `frontend`.
- Sub-module `lane_compactor`: combinational; maps mask plus lane data to a packed list and a count. Instantiated once; implemented as a prefix-sum over the mask.
- Top level holds entry storage, pointers, count and issue logic.

## Test plan
- Reset, then push pc=0x100 with mask 4'b1111 → next cycle `ins0` pc=0x100 and ins1 valid. After two pops, occupancy=0.
- Mask 4'b1010 at pc=0x200 → ins0 pc=0x201 and ins1_valid=0, because 0x203≠0x202. Second cycle ins0 pc=0x203.
- `push_pred_vld_i`=1, lane 1, target 0x400, mask 4'b1111 at 0x300 → only 0x300 and 0x301 enqueued. Issue shows pred_vld=1, pred_idx=1, pred_target=0x400.
- Exception code 4'h1 on a push at 0x500 → ins0 excp_vld=1 and ins1_valid=0 in that cycle.
- With C_DEPTH=16, fill to 13 → ready=0. Hold `rn_busy_i`=1 for 20 cycles → no loss. Then drain across the pointer wrap and check PCs in order.
- Flush while occupancy=9 and a push and pop are active → next cycle occupancy=0 and all valids=0. The dropped push never appears.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch instruction queue and the frontend.
package fetch_pkg;

    localparam int unsigned PC_W = 30;

    localparam logic [3:0] EXCP_NONE        = 4'h0;
    localparam logic [3:0] EXCP_BUS_DENIED  = 4'h1;
    localparam logic [3:0] EXCP_BUS_CORRUPT = 4'h2;

    typedef struct packed {
        logic [31:0]     insn;
        logic [PC_W-1:0] pc;
        logic            excp_vld;
        logic [3:0]      excp_code;
        logic            pred_tkn;
        logic [PC_W-1:0] pred_target;
    } fetch_entry_t;

endpackage

// File: rtl/lane_compactor.sv
// Packs the valid lanes of a fetch bundle into consecutive slots, lowest lane first.
module lane_compactor
    import fetch_pkg::*;
#(
    parameter int unsigned C_LANES = 4
) (
    input  logic [C_LANES-1:0]               mask_i,
    input  fetch_entry_t [C_LANES-1:0]       lanes_i,
    output fetch_entry_t [C_LANES-1:0]       packed_o,
    output logic [$clog2(C_LANES+1)-1:0]     count_o
);
    localparam int unsigned CNT_W = $clog2(C_LANES + 1);

    logic [CNT_W-1:0] prefix_s [C_LANES];

    // Exclusive prefix sum: destination slot of each lane.
    always_comb begin
        logic [CNT_W-1:0] run;
        run = '0;
        for (int i = 0; i < C_LANES; i++) begin
            prefix_s[i] = run;
            run = run + CNT_W'(mask_i[i]);
        end
        count_o = run;
    end

    // Each output slot selects the single valid lane whose prefix matches it.
    always_comb begin
        for (int j = 0; j < C_LANES; j++) begin
            packed_o[j] = '0;
            for (int i = 0; i < C_LANES; i++) begin
                if (mask_i[i] && (prefix_s[i] == CNT_W'(j))) begin
                    packed_o[j] = lanes_i[i];
                end else begin
                    packed_o[j] = packed_o[j];
                end
            end
        end
    end

endmodule

// File: rtl/fetch_insn_queue.sv
// Instruction-granular fetch queue: compacts fetch bundles into a circular buffer
// and issues up to two sequential instructions per cycle to decode.
module fetch_insn_queue
    import fetch_pkg::*;
#(
    parameter int unsigned C_FETCH_WIDTH = 4,
    parameter int unsigned C_DEPTH       = 16
) (
    input  logic                              core_clock_i,
    input  logic                              core_reset_ni,
    input  logic                              core_flush_i,
    input  logic                              push_valid_i,
    output logic                              push_ready_o,
    input  logic [PC_W-1:0]                   push_pc_i,
    input  logic [C_FETCH_WIDTH-1:0]          push_mask_i,
    input  logic [32*C_FETCH_WIDTH-1:0]       push_insn_i,
    input  logic                              push_excp_vld_i,
    input  logic [3:0]                        push_excp_code_i,
    input  logic                              push_pred_vld_i,
    input  logic [$clog2(C_FETCH_WIDTH)-1:0]  push_pred_lane_i,
    input  logic [PC_W-1:0]                   push_pred_target_i,
    output logic                              ins0_valid_o,
    output logic                              ins1_valid_o,
    output logic [31:0]                       ins0_insn_o,
    output logic [31:0]                       ins1_insn_o,
    output logic [PC_W-1:0]                   insbundle_pc_o,
    output logic                              ins0_excp_vld_o,
    output logic [3:0]                        ins0_excp_code_o,
    output logic                              ins1_excp_vld_o,
    output logic [3:0]                        ins1_excp_code_o,
    output logic                              pred_vld_o,
    output logic                              pred_idx_o,
    output logic [PC_W-1:0]                   pred_target_o,
    input  logic                              rn_busy_i,
    output logic [$clog2(C_DEPTH):0]          occupancy_o
);
    localparam int unsigned PTR_W  = $clog2(C_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = $clog2(C_FETCH_WIDTH);
    localparam int unsigned LCNT_W = $clog2(C_FETCH_WIDTH + 1);

    fetch_entry_t [C_FETCH_WIDTH-1:0] lane_s;
    fetch_entry_t [C_FETCH_WIDTH-1:0] packed_s;
    logic [C_FETCH_WIDTH-1:0]         mask_eff_s;
    logic [LCNT_W-1:0]                push_cnt_s;

    fetch_entry_t     mem_q [C_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_fire_s;
    logic [1:0]       pop_cnt_s;
    fetch_entry_t     head_e_s;
    fetch_entry_t     next_e_s;
    logic             ins0_vld_s;
    logic             ins1_vld_s;

    // Build per-lane entries; lanes past a predicted-taken branch are dropped.
    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < C_FETCH_WIDTH; i++) begin
            mask_eff_s[i]           = push_mask_i[i] &
                                      (~push_pred_vld_i | (LANE_W'(i) <= push_pred_lane_i));
            lane_s[i].insn          = push_insn_i[32*i +: 32];
            lane_s[i].pc            = push_pc_i + PC_W'(i);
            lane_s[i].excp_vld      = push_excp_vld_i & mask_eff_s[i] & ~seen;
            lane_s[i].excp_code     = push_excp_code_i;
            lane_s[i].pred_tkn      = push_pred_vld_i & (LANE_W'(i) == push_pred_lane_i);
            lane_s[i].pred_target   = push_pred_target_i;
            seen                    = seen | mask_eff_s[i];
        end
    end

    lane_compactor #(
        .C_LANES (C_FETCH_WIDTH)
    ) u_compactor (
        .mask_i   (mask_eff_s),
        .lanes_i  (lane_s),
        .packed_o (packed_s),
        .count_o  (push_cnt_s)
    );

    assign push_ready_o = (count_q <= CNT_W'(C_DEPTH - C_FETCH_WIDTH));
    assign push_fire_s  = push_valid_i & push_ready_o & ~core_flush_i;

    // Head/head+1 reads and dual-issue qualification.
    always_comb begin
        head_e_s   = mem_q[head_q];
        next_e_s   = mem_q[head_q + PTR_W'(1)];
        ins0_vld_s = (count_q != '0);
        ins1_vld_s = (count_q >= CNT_W'(2)) &&
                     (next_e_s.pc == head_e_s.pc + PC_W'(1)) &&
                     !head_e_s.pred_tkn && !head_e_s.excp_vld;
        if (rn_busy_i) begin
            pop_cnt_s = 2'd0;
        end else begin
            pop_cnt_s = {1'b0, ins0_vld_s} + {1'b0, ins1_vld_s};
        end
    end

    // Prediction output: head has priority over the second slot.
    always_comb begin
        pred_vld_o    = 1'b0;
        pred_idx_o    = 1'b0;
        pred_target_o = '0;
        if (ins0_vld_s && head_e_s.pred_tkn) begin
            pred_vld_o    = 1'b1;
            pred_target_o = head_e_s.pred_target;
        end else if (ins1_vld_s && next_e_s.pred_tkn) begin
            pred_vld_o    = 1'b1;
            pred_idx_o    = 1'b1;
            pred_target_o = next_e_s.pred_target;
        end else begin
            pred_vld_o    = 1'b0;
        end
    end

    // Pointer and count next-state; flush wins over any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (core_flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + PTR_W'(pop_cnt_s);
            if (push_fire_s) begin
                tail_d  = tail_q + PTR_W'(push_cnt_s);
                count_d = count_q + CNT_W'(push_cnt_s) - CNT_W'(pop_cnt_s);
            end else begin
                count_d = count_q - CNT_W'(pop_cnt_s);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; compacted writes may straddle the pointer wrap.
    always_ff @(posedge core_clock_i) begin
        if (push_fire_s) begin
            for (int j = 0; j < C_FETCH_WIDTH; j++) begin
                if (LCNT_W'(j) < push_cnt_s) begin
                    mem_q[tail_q + PTR_W'(j)] <= packed_s[j];
                end
            end
        end
    end

    assign ins0_valid_o     = ins0_vld_s;
    assign ins1_valid_o     = ins1_vld_s;
    assign ins0_insn_o      = head_e_s.insn;
    assign ins1_insn_o      = next_e_s.insn;
    assign insbundle_pc_o   = head_e_s.pc;
    assign ins0_excp_vld_o  = ins0_vld_s & head_e_s.excp_vld;
    assign ins0_excp_code_o = head_e_s.excp_code;
    assign ins1_excp_vld_o  = ins1_vld_s & next_e_s.excp_vld;
    assign ins1_excp_code_o = next_e_s.excp_code;
    assign occupancy_o      = count_q;

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Randomised and directed bench for fetch_insn_queue against a queue-based reference model.
module tb_fetch_insn_queue;

    logic         clk = 1'b0;
    logic         rst_n, flush, pv, pe, pp, busy;
    logic [29:0]  ppc, ptgt;
    logic [3:0]   pmask, pcode;
    logic [127:0] pinsn;
    logic [1:0]   plane;

    logic         ready, v0, v1, e0, e1, pvo, pidx;
    logic [31:0]  i0, i1;
    logic [29:0]  pc0, ptgo;
    logic [3:0]   c0, c1;
    logic [4:0]   occ;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] insn;
        logic [29:0] pc;
        bit          excp;
        logic [3:0]  code;
        bit          pred;
        logic [29:0] tgt;
    } m_ent_t;

    typedef struct packed {
        logic v0, v1; logic [4:0] occ; logic rdy; logic [29:0] pc;
        logic [31:0] i0; logic e0; logic [3:0] c0;
        logic [31:0] i1; logic e1; logic [3:0] c1;
        logic pv; logic pidx; logic [29:0] pt;
    } obs_t;

    m_ent_t mq[$];
    obs_t   got, want;

    fetch_insn_queue #(.C_FETCH_WIDTH(4), .C_DEPTH(16)) dut (
        .core_clock_i(clk), .core_reset_ni(rst_n), .core_flush_i(flush),
        .push_valid_i(pv), .push_ready_o(ready), .push_pc_i(ppc), .push_mask_i(pmask),
        .push_insn_i(pinsn), .push_excp_vld_i(pe), .push_excp_code_i(pcode),
        .push_pred_vld_i(pp), .push_pred_lane_i(plane), .push_pred_target_i(ptgt),
        .ins0_valid_o(v0), .ins1_valid_o(v1), .ins0_insn_o(i0), .ins1_insn_o(i1),
        .insbundle_pc_o(pc0), .ins0_excp_vld_o(e0), .ins0_excp_code_o(c0),
        .ins1_excp_vld_o(e1), .ins1_excp_code_o(c1), .pred_vld_o(pvo),
        .pred_idx_o(pidx), .pred_target_o(ptgo), .rn_busy_i(busy), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    function automatic bit m_dual();
        return (mq.size() >= 2) && (mq[1].pc == mq[0].pc + 30'd1) && !mq[0].pred && !mq[0].excp;
    endfunction

    function automatic obs_t model_obs();
        obs_t o = '0;
        o.occ = 5'(mq.size());
        o.rdy = (16 - mq.size()) >= 4;
        if (mq.size() >= 1) begin
            o.v0 = 1'b1; o.pc = mq[0].pc; o.i0 = mq[0].insn; o.e0 = mq[0].excp;
            o.c0 = mq[0].excp ? mq[0].code : 4'h0;
            if (mq[0].pred) begin o.pv = 1'b1; o.pt = mq[0].tgt; end
        end
        if (m_dual()) begin
            o.v1 = 1'b1; o.i1 = mq[1].insn; o.e1 = mq[1].excp;
            o.c1 = mq[1].excp ? mq[1].code : 4'h0;
            if (mq[1].pred) begin o.pv = 1'b1; o.pidx = 1'b1; o.pt = mq[1].tgt; end
        end
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o = '0;
        o.v0 = v0; o.v1 = v1; o.occ = occ; o.rdy = ready; o.pv = pvo;
        if (v0) begin o.pc = pc0; o.i0 = i0; o.e0 = e0; o.c0 = e0 ? c0 : 4'h0; end
        if (v1) begin o.i1 = i1; o.e1 = e1; o.c1 = e1 ? c1 : 4'h0; end
        if (pvo) begin o.pidx = pidx; o.pt = ptgo; end
        return o;
    endfunction

    // Reference behaviour of one clock edge, from the current inputs.
    task automatic model_step();
        int  npop;
        bit  rdy, first;
        m_ent_t e;
        rdy = (16 - mq.size()) >= 4;
        if (flush) begin
            mq.delete();
        end else begin
            npop = busy ? 0 : ((mq.size() >= 1 ? 1 : 0) + (m_dual() ? 1 : 0));
            repeat (npop) void'(mq.pop_front());
            if (pv && rdy) begin
                first = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (pp && k > int'(plane)) break;
                    if (pmask[k]) begin
                        e.insn = pinsn[32*k +: 32]; e.pc = ppc + 30'(k);
                        e.excp = pe && first; e.code = pcode;
                        e.pred = pp && (k == int'(plane)); e.tgt = ptgt;
                        first = 1'b0;
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [29:0] pc, input logic [3:0] m,
                         input logic ex, input logic [3:0] cd, input logic pr,
                         input logic [1:0] ln, input logic [29:0] tg, input logic b,
                         input logic f);
        pv = v; ppc = pc; pmask = m; pe = ex; pcode = cd; pp = pr; plane = ln;
        ptgt = tg; busy = b; flush = f;
        for (int k = 0; k < 4; k++) pinsn[32*k +: 32] = $urandom();
    endtask

    task automatic idle(input logic b);
        drive(1'b0, 30'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, b, 1'b0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || occ !== 5'd0 || v0 !== 1'b0 || v1 !== 1'b0 ||
            e0 !== 1'b0 || e1 !== 1'b0 || pvo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b occ=%0d v0=%b v1=%b e0=%b e1=%b pv=%b, want 1 0 0 0 0 0 0",
                     ready, occ, v0, v1, e0, e1, pvo);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 30'h100, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        n_cmp++;
        if (v0 !== 1'b1 || pc0 !== 30'h100 || v1 !== 1'b1 || occ !== 5'd4) begin
            n_fail++;
            $display("FAIL basic_issue: v0=%b pc=%h v1=%b occ=%0d, want 1 100 1 4", v0, pc0, v1, occ);
        end
        got = observe(); want = model_obs(); n_cmp++;
        if (got !== want) begin n_fail++; $display("FAIL basic_model: got %h want %h", got, want); end
        idle(1'b0);
        tick(); tick();
        n_cmp++;
        if (occ !== 5'd0 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: occ=%0d v0=%b, want 0 0", occ, v0);
        end
    endtask

    task automatic test_sparse_mask();
        drive(1'b1, 30'h200, 4'b1010, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        n_cmp++;
        if (v0 !== 1'b1 || pc0 !== 30'h201 || v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_first: v0=%b pc=%h v1=%b, want 1 201 0", v0, pc0, v1);
        end
        tick();
        n_cmp++;
        if (v0 !== 1'b1 || pc0 !== 30'h203) begin
            n_fail++;
            $display("FAIL sparse_second: v0=%b pc=%h, want 1 203", v0, pc0);
        end
        tick();
    endtask

    task automatic test_pred();
        drive(1'b1, 30'h300, 4'b1111, 1'b0, 4'h0, 1'b1, 2'd1, 30'h400, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        n_cmp++;
        if (occ !== 5'd2 || v1 !== 1'b1 || pvo !== 1'b1 || pidx !== 1'b1 || ptgo !== 30'h400) begin
            n_fail++;
            $display("FAIL pred: occ=%0d v1=%b pv=%b idx=%b tgt=%h, want 2 1 1 1 400",
                     occ, v1, pvo, pidx, ptgo);
        end
        idle(1'b0);
        tick();
    endtask

    task automatic test_excp();
        drive(1'b1, 30'h500, 4'b1111, 1'b1, 4'h1, 1'b0, 2'd0, 30'h0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        n_cmp++;
        if (e0 !== 1'b1 || c0 !== 4'h1 || v1 !== 1'b0 || pc0 !== 30'h500) begin
            n_fail++;
            $display("FAIL excp: e0=%b code=%h v1=%b pc=%h, want 1 1 0 500", e0, c0, v1, pc0);
        end
        idle(1'b0);
        for (int c = 0; c < 4; c++) begin
            got = observe(); want = model_obs(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL excp_drain %0d: got %h want %h", c, got, want); end
            tick();
        end
    endtask

    task automatic test_full_wrap();
        logic [29:0] exp_pc;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 30'h1000 + 30'(4*k), 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 30'h100C, 4'b0001, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (occ !== 5'd13 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_level: occ=%0d ready=%b, want 13 0", occ, ready);
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 30'h2000, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0);
            got = observe(); want = model_obs(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL full_hold %0d: got %h want %h", c, got, want); end
            tick();
        end
        n_cmp++;
        if (occ !== 5'd13) begin
            n_fail++;
            $display("FAIL full_noloss: occ=%0d, want 13", occ);
        end
        idle(1'b0);
        exp_pc = 30'h1000;
        for (int c = 0; c < 10; c++) begin
            if (v0 === 1'b1) begin
                n_cmp++;
                if (pc0 !== exp_pc) begin
                    n_fail++;
                    $display("FAIL wrap_order %0d: pc=%h, want %h", c, pc0, exp_pc);
                end
                exp_pc = exp_pc + ((v1 === 1'b1) ? 30'd2 : 30'd1);
            end
            tick();
        end
        n_cmp++;
        if (exp_pc !== 30'h100D || occ !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_end: next pc=%h occ=%0d, want 100d 0", exp_pc, occ);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 30'h3000, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0); tick();
        drive(1'b1, 30'h3004, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0); tick();
        drive(1'b1, 30'h3008, 4'b0001, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0); tick();
        drive(1'b1, 30'h4000, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b0, 1'b1);
        n_cmp++;
        if (occ !== 5'd9) begin n_fail++; $display("FAIL flush_pre: occ=%0d, want 9", occ); end
        tick();
        idle(1'b0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (occ !== 5'd0 || v0 !== 1'b0 || v1 !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_after %0d: occ=%0d v0=%b v1=%b, want 0 0 0", c, occ, v0, v1);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 30'h5000, 4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (occ !== 5'd0 || v0 !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: occ=%0d v0=%b ready=%b, want 0 0 1", occ, v0, ready);
        end
        mq.delete();
        #1 rst_n = 1'b1;
        drive(1'b1, 30'h6000, 4'b0011, 1'b0, 4'h0, 1'b0, 2'd0, 30'h0, 1'b1, 1'b0);
        tick();
        idle(1'b0);
        n_cmp++;
        if (v0 !== 1'b1 || pc0 !== 30'h6000 || occ !== 5'd2) begin
            n_fail++;
            $display("FAIL reset_release: v0=%b pc=%h occ=%0d, want 1 6000 2", v0, pc0, occ);
        end
        tick();
    endtask

    task automatic test_random();
        logic [29:0] rpc;
        rpc = 30'h8000;
        for (int c = 0; c < 600; c++) begin
            got = observe(); want = model_obs(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL random %0d: got %h want %h", c, got, want); end
            drive(($urandom % 4) != 0,
                  (($urandom % 4) == 0) ? 30'($urandom) : rpc,
                  4'($urandom), ($urandom % 8) == 0, 4'($urandom),
                  ($urandom % 4) == 0, 2'($urandom), 30'($urandom),
                  ($urandom % 3) == 0, ($urandom % 40) == 0);
            rpc = ppc + 30'd4;
            tick();
        end
        idle(1'b0);
        for (int c = 0; c < 12; c++) begin
            got = observe(); want = model_obs(); n_cmp++;
            if (got !== want) begin n_fail++; $display("FAIL random_drain %0d: got %h want %h", c, got, want); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sparse_mask();
        test_pred();
        test_excp();
        test_full_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
